// File: rtl/hdmi_packet_scheduler.sv
// rtl/hdmi_packet_scheduler.sv - HDMI data-island packet arbiter; SPD source compiled in by HDMI_SPD_INFOFRAME_EN
module hdmi_packet_scheduler #(
  parameter int PACKET_CLOCKS = 32,
  parameter int DROP_CNT_W    = 8
) (
  input  logic                             clk_pixel,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             slot_start,
  input  logic                             frame_start,
  input  logic                             acr_wrap,
  input  logic                             audio_sample_avail,
  output logic                             packet_active,
  output logic [7:0]                       packet_type,
  output logic [$clog2(PACKET_CLOCKS)-1:0] packet_counter,
  output logic                             acr_ack,
  output logic                             audio_sample_ack,
  output logic                             avi_ack,
  output logic                             audio_if_ack,
  output logic                             spd_ack,
  output logic [DROP_CNT_W-1:0]            acr_drop_count,
  output logic                             slot_overrun
);

  localparam int               CNT_W    = $clog2(PACKET_CLOCKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACKET_CLOCKS - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PACKET_CLOCKS - 2);

  localparam logic [7:0] T_NULL = 8'h00;
  localparam logic [7:0] T_ACR  = 8'h01;
  localparam logic [7:0] T_AUD  = 8'h02;
  localparam logic [7:0] T_AVI  = 8'h82;
  localparam logic [7:0] T_AIF  = 8'h84;
  localparam logic [7:0] T_SPD  = 8'h83;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [7:0]            type_q;
  logic                  active_q;

  logic                  acr_shadow_q;
  logic                  acr_pend_q, acr_pend_d;
  logic                  avi_pend_q, avi_pend_d;
  logic                  aif_pend_q, aif_pend_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  overrun_q;

  logic                  acr_ack_q, aud_ack_q, avi_ack_q, aif_ack_q;

  logic                  last_clk;
  logic                  pre_last;
  logic                  acr_req;
  logic                  clr_acr, clr_avi, clr_aif;
  logic                  spd_elig;
  logic [7:0]            win_type;

  // The final clock of a packet is where its source is retired; the clock
  // before it arms the registered ack so the pulse lands on the final clock.
  assign last_clk = (state_q == S_SEND) && (cnt_q == CNT_LAST);
  assign pre_last = (state_q == S_SEND) && (cnt_q == CNT_PRE);
  assign acr_req  = acr_wrap ^ acr_shadow_q;

  assign clr_acr  = last_clk && (type_q == T_ACR);
  assign clr_avi  = last_clk && (type_q == T_AVI);
  assign clr_aif  = last_clk && (type_q == T_AIF);

`ifdef HDMI_SPD_INFOFRAME_EN
  logic spd_pend_q, spd_pend_d;
  logic clr_spd;
  logic spd_ack_q;

  assign clr_spd    = last_clk && (type_q == T_SPD);
  assign spd_elig   = spd_pend_q & ~clr_spd;
  assign spd_pend_d = enable & (frame_start | (spd_pend_q & ~clr_spd));
  assign spd_ack    = spd_ack_q;

  // SPD pending flag and its completion pulse
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      spd_pend_q <= 1'b0;
      spd_ack_q  <= 1'b0;
    end else begin
      spd_pend_q <= spd_pend_d;
      spd_ack_q  <= pre_last && (type_q == T_SPD);
    end
  end
`else
  assign spd_elig = 1'b0;
  assign spd_ack  = 1'b0;
`endif

  // Fixed-priority pick from the registered flags. A flagged source whose
  // packet is finishing this clock is skipped for this one decision, since
  // its flag still reads set until the clear lands. Audio samples are a live
  // level with no flag, so they stay eligible back-to-back.
  always_comb begin
    win_type = T_NULL;
    if (acr_pend_q && !clr_acr) begin
      win_type = T_ACR;
    end else if (audio_sample_avail) begin
      win_type = T_AUD;
    end else if (avi_pend_q && !clr_avi) begin
      win_type = T_AVI;
    end else if (aif_pend_q && !clr_aif) begin
      win_type = T_AIF;
    end else if (spd_elig) begin
      win_type = T_SPD;
    end
  end

  // Pending-flag next state (set beats clear) and saturating ACR drop count
  always_comb begin
    acr_pend_d = enable & (acr_req     | (acr_pend_q & ~clr_acr));
    avi_pend_d = enable & (frame_start | (avi_pend_q & ~clr_avi));
    aif_pend_d = enable & (frame_start | (aif_pend_q & ~clr_aif));
    drop_d     = drop_q;
    if (enable && acr_req && acr_pend_q && !clr_acr &&
        (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // Request flags, ACR edge shadow and drop counter
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acr_shadow_q <= acr_wrap;
      acr_pend_q   <= 1'b0;
      avi_pend_q   <= 1'b0;
      aif_pend_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      acr_shadow_q <= acr_wrap;
      acr_pend_q   <= acr_pend_d;
      avi_pend_q   <= avi_pend_d;
      aif_pend_q   <= aif_pend_d;
      drop_q       <= drop_d;
    end
  end

  // Slot FSM: start on an enabled slot, count through the packet, chain on a
  // slot that coincides with the final clock, otherwise fall back to idle
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      type_q   <= T_NULL;
      active_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (slot_start && enable) begin
            type_q   <= win_type;
            active_q <= 1'b1;
            state_q  <= S_SEND;
          end
        end
        S_SEND: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (slot_start && enable) begin
              type_q <= win_type;
            end else begin
              active_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  // Completion pulses, registered one clock ahead so they coincide with the final clock
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acr_ack_q <= 1'b0;
      aud_ack_q <= 1'b0;
      avi_ack_q <= 1'b0;
      aif_ack_q <= 1'b0;
    end else begin
      acr_ack_q <= pre_last && (type_q == T_ACR);
      aud_ack_q <= pre_last && (type_q == T_AUD);
      avi_ack_q <= pre_last && (type_q == T_AVI);
      aif_ack_q <= pre_last && (type_q == T_AIF);
    end
  end

  // Sticky flag for a slot offered while a packet is still mid-flight
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if ((state_q == S_SEND) && slot_start && (cnt_q != CNT_LAST)) begin
      overrun_q <= 1'b1;
    end
  end

  assign packet_active    = active_q;
  assign packet_type      = type_q;
  assign packet_counter   = cnt_q;
  assign acr_ack          = acr_ack_q;
  assign audio_sample_ack = aud_ack_q;
  assign avi_ack          = avi_ack_q;
  assign audio_if_ack     = aif_ack_q;
  assign acr_drop_count   = drop_q;
  assign slot_overrun     = overrun_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// tb/tb_hdmi_packet_scheduler.sv - scoreboard bench for hdmi_packet_scheduler
module tb_hdmi_packet_scheduler;

  localparam int P    = 32;
  localparam int DW   = 8;
  localparam int DMAX = (1 << DW) - 1;

  localparam logic [7:0] T_NULL = 8'h00;
  localparam logic [7:0] T_ACR  = 8'h01;
  localparam logic [7:0] T_AUD  = 8'h02;
  localparam logic [7:0] T_AVI  = 8'h82;
  localparam logic [7:0] T_AIF  = 8'h84;
  localparam logic [7:0] T_SPD  = 8'h83;

`ifdef HDMI_SPD_INFOFRAME_EN
  localparam bit SPD_EN = 1'b1;
`else
  localparam bit SPD_EN = 1'b0;
`endif

  logic          clk_pixel = 1'b0;
  logic          reset;
  logic          enable;
  logic          slot_start;
  logic          frame_start;
  logic          acr_wrap;
  logic          audio_sample_avail;
  logic          packet_active;
  logic [7:0]    packet_type;
  logic [4:0]    packet_counter;
  logic          acr_ack;
  logic          audio_sample_ack;
  logic          avi_ack;
  logic          audio_if_ack;
  logic          spd_ack;
  logic [DW-1:0] acr_drop_count;
  logic          slot_overrun;

  hdmi_packet_scheduler #(.PACKET_CLOCKS(P), .DROP_CNT_W(DW)) dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .enable             (enable),
    .slot_start         (slot_start),
    .frame_start        (frame_start),
    .acr_wrap           (acr_wrap),
    .audio_sample_avail (audio_sample_avail),
    .packet_active      (packet_active),
    .packet_type        (packet_type),
    .packet_counter     (packet_counter),
    .acr_ack            (acr_ack),
    .audio_sample_ack   (audio_sample_ack),
    .avi_ack            (avi_ack),
    .audio_if_ack       (audio_if_ack),
    .spd_ack            (spd_ack),
    .acr_drop_count     (acr_drop_count),
    .slot_overrun       (slot_overrun)
  );

  always #5 clk_pixel = ~clk_pixel;

  int vectors    = 0;
  int miscompares = 0;

  // Expected packet starts and expected completion sources, in order
  logic [7:0] exp_type_q[$];
  logic [7:0] exp_ack_q[$];

  // Reference model state: what the outputs should show in the current clock
  bit         m_acr, m_avi, m_aif, m_spd, m_shadow, m_busy, m_ovr;
  int         m_idx, m_drop;
  logic [7:0] m_type;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acr = 0; m_avi = 0; m_aif = 0; m_spd = 0;
    m_busy = 0; m_ovr = 0; m_idx = 0; m_drop = 0;
    m_type = T_NULL;
    m_shadow = acr_wrap;
    exp_type_q.delete();
    exp_ack_q.delete();
  endtask

  // Advance the model across one rising edge given the inputs now driven
  task automatic model_step();
    bit         last, fin_acr, fin_avi, fin_aif, fin_spd, req, acc;
    logic [7:0] cands[$];
    logic [7:0] win;
    last    = m_busy && (m_idx == P - 1);
    fin_acr = last && (m_type == T_ACR);
    fin_avi = last && (m_type == T_AVI);
    fin_aif = last && (m_type == T_AIF);
    fin_spd = last && (m_type == T_SPD);
    if (m_acr && !fin_acr) cands.push_back(T_ACR);
    if (audio_sample_avail) cands.push_back(T_AUD);
    if (m_avi && !fin_avi) cands.push_back(T_AVI);
    if (m_aif && !fin_aif) cands.push_back(T_AIF);
    if (m_spd && !fin_spd) cands.push_back(T_SPD);
    win = (cands.size() > 0) ? cands[0] : T_NULL;
    acc = enable && slot_start && (!m_busy || last);
    if (m_busy && !last && slot_start) m_ovr = 1;
    req = (acr_wrap != m_shadow);
    if (enable && req && m_acr && !fin_acr && m_drop < DMAX) m_drop++;
    m_acr = enable && (req || (m_acr && !fin_acr));
    m_avi = enable && (frame_start || (m_avi && !fin_avi));
    m_aif = enable && (frame_start || (m_aif && !fin_aif));
    m_spd = SPD_EN && enable && (frame_start || (m_spd && !fin_spd));
    m_shadow = acr_wrap;
    if (acc) begin
      m_busy = 1; m_idx = 0; m_type = win;
      exp_type_q.push_back(win);
      if (win != T_NULL) exp_ack_q.push_back(win);
    end else if (last) begin
      m_busy = 0; m_idx = 0;
    end else if (m_busy) begin
      m_idx++;
    end
  endtask

  task automatic check_status();
    chk("packet_active", packet_active, m_busy);
    chk("packet_counter", packet_counter, m_busy ? m_idx : 0);
    chk("packet_type", packet_type, m_type);
    chk("acr_drop_count", acr_drop_count, m_drop);
    chk("slot_overrun", slot_overrun, m_ovr);
  endtask

  task automatic cyc(input bit s, input bit f, input bit t, input bit a, input bit e);
    @(negedge clk_pixel);
    check_status();
    reset = 0;
    slot_start = s;
    frame_start = f;
    if (t) acr_wrap = ~acr_wrap;
    audio_sample_avail = a;
    enable = e;
    model_step();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_pixel);
      reset = 1; slot_start = 0; frame_start = 0;
      audio_sample_avail = 0; enable = 1;
      model_reset();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
  endtask

  task automatic run_to_last(input bit a);
    for (int i = 0; i < P + 2 && !(m_busy && m_idx == P - 1); i++) cyc(0, 0, 0, a, 1);
  endtask

  task automatic run_to_idx(input int k);
    for (int i = 0; i < P + 2 && !(m_busy && m_idx == k); i++) cyc(0, 0, 0, 0, 1);
  endtask

  // Monitor: each packet start pops an expected type; each ack pops an expected source
  logic [4:0] ack_vec;
  logic [7:0] ack_code;
  always @(posedge clk_pixel) begin
    #1;
    if (reset === 1'b0) begin
      if (packet_active === 1'b1 && packet_counter == 0) begin
        if (exp_type_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_packet: got type %0h, expected none at %0t", packet_type, $time);
        end else begin
          chk("packet_start_type", packet_type, exp_type_q.pop_front());
        end
      end
      ack_vec = {acr_ack, audio_sample_ack, avi_ack, audio_if_ack, spd_ack};
      if (ack_vec !== 5'b0) begin
        ack_code = acr_ack ? T_ACR : audio_sample_ack ? T_AUD : avi_ack ? T_AVI :
                   audio_if_ack ? T_AIF : T_SPD;
        if ($countones(ack_vec) != 1) ack_code = 8'hEE;
        if (exp_ack_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_ack: got acks %b, expected none at %0t", ack_vec, $time);
        end else begin
          chk("ack_source", ack_code, exp_ack_q.pop_front());
        end
        chk("ack_on_last_clock", packet_counter, P - 1);
      end
    end
  end

  initial begin
    bit av, en, s, f, t;
    reset = 1; enable = 1; slot_start = 0; frame_start = 0;
    acr_wrap = 1; audio_sample_avail = 0;
    do_reset(3);

    // Null packet on an empty schedule
    idle(3);
    cyc(1, 0, 0, 0, 1);
    idle(P + 4);

    // Priority order, then back-to-back slots
    cyc(0, 1, 1, 1, 1);
    cyc(1, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      run_to_last(1);
      cyc(1, 0, 0, 1, 1);
    end
    for (int k = 0; k < 3; k++) begin
      run_to_last(0);
      cyc(1, 0, 0, 0, 1);
    end
    run_to_last(0);
    idle(4);

    // Two ACR requests with no slot between: one dropped
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    idle(2);
    cyc(1, 0, 0, 0, 1);
    run_to_last(0);
    idle(3);

    // ACR request landing on the ACR ack clock survives
    cyc(0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 1);
    run_to_last(0);
    cyc(0, 0, 1, 0, 1);
    idle(3);
    cyc(1, 0, 0, 0, 1);
    run_to_last(0);
    idle(3);

    // Slot offered mid-packet
    cyc(1, 0, 0, 0, 1);
    run_to_idx(10);
    cyc(1, 0, 0, 0, 1);
    run_to_last(0);
    idle(3);

    // Disable mid-packet with frame flags pending
    cyc(0, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    idle(5);
    for (int i = 0; i < P + 4; i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    idle(0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 1);
    run_to_last(0);
    idle(3);

    // Reset while a packet is in flight: no ack follows
    cyc(0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 1);
    idle(10);
    do_reset(2);
    idle(P + 8);

    // Randomized traffic
    av = 0; en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) av = ~av;
      if ($urandom_range(0, 199) == 0) en = ~en;
      if (m_busy && m_idx == P - 1) s = ($urandom_range(0, 3) != 0);
      else s = ($urandom_range(0, 24) == 0);
      f = ($urandom_range(0, 59) == 0);
      t = ($urandom_range(0, 9) == 0);
      cyc(s, f, t, av, en);
    end
    idle(2 * P + 8);

    chk("ack_queue_drained", exp_ack_q.size(), 0);
    chk("type_queue_drained", exp_type_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
